// File: rtl/coord_uart_tx_pkg.sv
// Shared frame constants, one-hot sequencer encoding and BCD helpers
// for the coordinate UART transmitter.
package coord_uart_tx_pkg;

  localparam logic [7:0] SOF     = 8'h0B;
  localparam logic [7:0] SEP     = 8'h44;
  localparam logic [7:0] EOF     = 8'h0A;
  localparam logic [7:0] ASCII_0 = 8'h30;

  localparam logic [9:0] COORD_MAX   = 10'd999;
  localparam int         CONV_CYCLES = 10;
  localparam int         NUM_COORD   = 2;

  typedef enum logic [6:0] {
    ST_IDLE = 7'b0000001,
    ST_CONV = 7'b0000010,
    ST_HDR  = 7'b0000100,
    ST_XDIG = 7'b0001000,
    ST_SEP  = 7'b0010000,
    ST_YDIG = 7'b0100000,
    ST_LF   = 7'b1000000
  } state_t;

  typedef struct packed {
    logic [3:0] hun;
    logic [3:0] ten;
    logic [3:0] uni;
  } bcd3_t;

  function automatic logic [9:0] saturate(input logic [9:0] v);
    return (v > COORD_MAX) ? COORD_MAX : v;
  endfunction

  // One double-dabble iteration on {bcd[11:0], bin[9:0]}: add-3 then shift.
  function automatic logic [21:0] dd_step(input logic [21:0] s);
    logic [21:0] t;
    t = s;
    for (int i = 0; i < 3; i++) begin
      if (t[10+4*i +: 4] >= 4'd5)
        t[10+4*i +: 4] = t[10+4*i +: 4] + 4'd3;
    end
    return {t[20:0], 1'b0};
  endfunction

  // Index of the most significant digit to send (2 = hundreds, 0 = units).
  function automatic logic [1:0] lead_digit(input bcd3_t v);
    if (v.hun != 4'd0)      return 2'd2;
    else if (v.ten != 4'd0) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [3:0] digit_at(input bcd3_t v, input logic [1:0] idx);
    case (idx)
      2'd2:    return v.hun;
      2'd1:    return v.ten;
      default: return v.uni;
    endcase
  endfunction

endpackage

// File: rtl/coord_uart_tx_ser.sv
// 8N1 byte serialiser. A start arriving in the last cycle of a stop bit is
// taken back-to-back; any other start while busy is ignored.
module uart_byte_ser #(
  parameter int BAUD_CNT_MAX = 5208
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_byte,
  input  logic       start,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CNT_W = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;

  logic [CNT_W-1:0] baud_cnt_reg;
  logic [3:0]       bit_cnt_reg;
  logic [9:0]       frame_reg;
  logic             busy_reg;
  logic             tx_reg;
  logic             bit_end;
  logic             load;

  assign bit_end = busy_reg && (baud_cnt_reg == CNT_W'(BAUD_CNT_MAX - 1));
  assign done    = bit_end && (bit_cnt_reg == 4'd9);
  assign load    = start && (!busy_reg || done);
  assign busy    = busy_reg;
  assign tx      = tx_reg;

  // tx is a registered copy of the current cell, so every bit keeps its width
  // and back-to-back bytes stay gapless on the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      frame_reg    <= '1;
      busy_reg     <= 1'b0;
      tx_reg       <= 1'b1;
    end else begin
      tx_reg <= busy_reg ? frame_reg[0] : 1'b1;
      if (load) begin
        busy_reg     <= 1'b1;
        baud_cnt_reg <= '0;
        bit_cnt_reg  <= '0;
        frame_reg    <= {1'b1, tx_byte, 1'b0};
      end else if (done) begin
        busy_reg     <= 1'b0;
        baud_cnt_reg <= '0;
        bit_cnt_reg  <= '0;
      end else if (bit_end) begin
        baud_cnt_reg <= '0;
        bit_cnt_reg  <= bit_cnt_reg + 4'd1;
        frame_reg    <= {1'b1, frame_reg[9:1]};
      end else if (busy_reg) begin
        baud_cnt_reg <= baud_cnt_reg + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/coord_uart_tx.sv
// Coordinate pair -> "0B x 'D' y 0A" decimal ASCII frame over 8N1 UART.
// Define COORD_TX_FIXED3_EN to always send three zero-padded digits per value.
module coord_uart_tx
  import coord_uart_tx_pkg::*;
#(
  parameter int UART_BPS = 9600,
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] coor_x,
  input  logic [9:0] coor_y,
  input  logic       coor_valid,
  output logic       coor_ready,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;

  state_t      state_reg, state_next;
  logic [1:0]  dig_reg, dig_next;
  logic [3:0]  conv_cnt_reg;
  logic        armed_reg;
  logic        last_bit_reg;
  logic        frame_done_reg;
  logic        accept;

  logic        ser_start;
  logic [7:0]  ser_byte;
  logic        ser_busy;
  logic        ser_done;

  logic [9:0]  coor_in   [NUM_COORD];
  bcd3_t       bcd_val   [NUM_COORD];
  logic [1:0]  first_dig [NUM_COORD];

  assign coor_in[0] = coor_x;
  assign coor_in[1] = coor_y;

  // last_bit_reg covers the final tx cell of the LF stop bit.
  assign coor_ready = (state_reg == ST_IDLE) && armed_reg && !last_bit_reg;
  assign busy       = (state_reg != ST_IDLE) || last_bit_reg;
  assign frame_done = frame_done_reg;
  assign accept     = coor_valid && coor_ready;

  for (genvar gi = 0; gi < NUM_COORD; gi++) begin : g_conv
    logic [9:0] bin_reg;
    bcd3_t      bcd_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        bin_reg <= '0;
        bcd_reg <= '0;
      end else if (accept) begin
        bin_reg <= saturate(coor_in[gi]);
        bcd_reg <= '0;
      end else if (state_reg == ST_CONV) begin
        {bcd_reg, bin_reg} <= dd_step({bcd_reg, bin_reg});
      end
    end

    assign bcd_val[gi] = bcd_reg;
`ifdef COORD_TX_FIXED3_EN
    assign first_dig[gi] = 2'd2;
`else
    assign first_dig[gi] = lead_digit(bcd_reg);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      dig_reg   <= 2'd0;
    end else begin
      state_reg <= state_next;
      dig_reg   <= dig_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_cnt_reg   <= '0;
      armed_reg      <= 1'b0;
      last_bit_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      armed_reg      <= 1'b1;
      last_bit_reg   <= (state_reg == ST_LF) && ser_done;
      frame_done_reg <= last_bit_reg;
      if (state_reg == ST_CONV)
        conv_cnt_reg <= conv_cnt_reg + 4'd1;
      else
        conv_cnt_reg <= '0;
    end
  end

  always_comb begin
    state_next = state_reg;
    dig_next   = dig_reg;
    unique case (state_reg)
      ST_IDLE: if (accept) state_next = ST_CONV;
      ST_CONV: if (conv_cnt_reg == 4'(CONV_CYCLES - 1)) state_next = ST_HDR;
      ST_HDR: if (ser_done) begin
        state_next = ST_XDIG;
        dig_next   = first_dig[0];
      end
      ST_XDIG: if (ser_done) begin
        if (dig_reg == 2'd0) state_next = ST_SEP;
        else                 dig_next   = dig_reg - 2'd1;
      end
      ST_SEP: if (ser_done) begin
        state_next = ST_YDIG;
        dig_next   = first_dig[1];
      end
      ST_YDIG: if (ser_done) begin
        if (dig_reg == 2'd0) state_next = ST_LF;
        else                 dig_next   = dig_reg - 2'd1;
      end
      ST_LF: if (ser_done) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // The next byte is chosen from the next state so it can be handed over in
  // the same cycle the current stop bit finishes.
  always_comb begin
    ser_byte = EOF;
    case (state_next)
      ST_HDR:  ser_byte = SOF;
      ST_XDIG: ser_byte = ASCII_0 + {4'd0, digit_at(bcd_val[0], dig_next)};
      ST_SEP:  ser_byte = SEP;
      ST_YDIG: ser_byte = ASCII_0 + {4'd0, digit_at(bcd_val[1], dig_next)};
      default: ser_byte = EOF;
    endcase
    ser_start = ((state_reg == ST_HDR) && !ser_busy)
             || (ser_done && (state_next != ST_IDLE));
  end

  uart_byte_ser #(
    .BAUD_CNT_MAX(BAUD_CNT_MAX)
  ) u_ser (
    .clk    (clk),
    .rst_n  (rst_n),
    .tx_byte(ser_byte),
    .start  (ser_start),
    .tx     (tx),
    .busy   (ser_busy),
    .done   (ser_done)
  );

endmodule

// File: tb/tb_coord_uart_tx.sv
// Directed bench for coord_uart_tx: decodes the UART line and checks frame
// bytes, bit widths, start latency, inter-byte gaps and frame_done timing.
module tb_coord_uart_tx;

  localparam int BAUD = 8;

  typedef int bq_t[$];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] coor_x = '0;
  logic [9:0] coor_y = '0;
  logic       coor_valid = 1'b0;
  logic       coor_ready;
  logic       tx;
  logic       busy;
  logic       frame_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int rx_byte_q[$];
  int rx_start_q[$];
  bit rx_clean_q[$];
  int acc_q[$];
  int done_q[$];
  bit done_ok_q[$];
  logic prev_busy = 1'b0;

  coord_uart_tx #(
    .UART_BPS(10),
    .CLK_FREQ(80)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .coor_x    (coor_x),
    .coor_y    (coor_y),
    .coor_valid(coor_valid),
    .coor_ready(coor_ready),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (coor_valid && coor_ready) acc_q.push_back(cyc + 1);
    if (frame_done) begin
      done_q.push_back(cyc);
      done_ok_q.push_back(!busy && prev_busy);
    end
    prev_busy = busy;
  end

  // UART receiver: samples every cycle of every cell so width errors show up.
  initial begin : rx_mon
    int st;
    bit clean;
    bit abort;
    logic [9:0] bits;
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
        st = cyc; clean = 1'b1; abort = 1'b0; bits = '0;
        for (int k = 0; k < 10 && !abort; k++) begin
          for (int j = 0; j < BAUD; j++) begin
            if (!(k == 0 && j == 0)) @(negedge clk);
            if (!rst_n) abort = 1'b1;
            if (j == 0) bits[k] = tx;
            else if (tx !== bits[k]) clean = 1'b0;
          end
        end
        if (!abort) begin
          rx_byte_q.push_back(int'(bits[8:1]));
          rx_start_q.push_back(st);
          rx_clean_q.push_back(clean && bits[0] == 1'b0 && bits[9] == 1'b1);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_pair(input int x, input int y);
    int n;
    n = 0;
    @(negedge clk);
    while (coor_ready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    chk("ready_before_accept", coor_ready, 1);
    @(posedge clk); #1;
    coor_x = 10'(x); coor_y = 10'(y); coor_valid = 1'b1;
    @(posedge clk); #1;
    chk("busy_after_accept", busy, 1);
    chk("ready_low_after_accept", coor_ready, 0);
  endtask

  task automatic check_frame(input string tag, input bq_t exp);
    int n, acc, b, st, prev, d;
    bit c, ok;
    n = 0;
    while (done_q.size() == 0 && n < 3000) begin @(negedge clk); n++; end
    chk({tag, " frame_done_seen"}, done_q.size() > 0, 1);
    acc  = (acc_q.size() > 0) ? acc_q.pop_front() : -1;
    prev = 0;
    chk({tag, " length"}, rx_byte_q.size(), exp.size());
    for (int i = 0; i < exp.size() && rx_byte_q.size() > 0; i++) begin
      b  = rx_byte_q.pop_front();
      st = rx_start_q.pop_front();
      c  = rx_clean_q.pop_front();
      chk($sformatf("%s byte%0d", tag, i), b, exp[i]);
      chk($sformatf("%s bits%0d", tag, i), c, 1);
      if (i == 0) chk({tag, " start_latency"}, st - acc, 12);
      else        chk($sformatf("%s gap%0d", tag, i), st - prev, 10 * BAUD);
      prev = st;
    end
    rx_byte_q.delete(); rx_start_q.delete(); rx_clean_q.delete();
    if (done_q.size() > 0) begin
      d  = done_q.pop_front();
      ok = done_ok_q.pop_front();
      chk({tag, " done_time"}, d - prev, 10 * BAUD);
      chk({tag, " done_with_busy_fall"}, ok, 1);
    end
    $display("frame %s: %0d bytes expected, checks so far %0d", tag, exp.size(), checks);
  endtask

  initial begin : stim
    bq_t f_123_45, f_0_0, f_sat, f_5_600, f_60_9, f_1_2, f_7_42, f_100_10;
    int n, b;
`ifdef COORD_TX_FIXED3_EN
    f_123_45 = '{'h0B, 'h31, 'h32, 'h33, 'h44, 'h30, 'h34, 'h35, 'h0A};
    f_0_0    = '{'h0B, 'h30, 'h30, 'h30, 'h44, 'h30, 'h30, 'h30, 'h0A};
    f_5_600  = '{'h0B, 'h30, 'h30, 'h35, 'h44, 'h36, 'h30, 'h30, 'h0A};
    f_60_9   = '{'h0B, 'h30, 'h36, 'h30, 'h44, 'h30, 'h30, 'h39, 'h0A};
    f_1_2    = '{'h0B, 'h30, 'h30, 'h31, 'h44, 'h30, 'h30, 'h32, 'h0A};
    f_7_42   = '{'h0B, 'h30, 'h30, 'h37, 'h44, 'h30, 'h34, 'h32, 'h0A};
    f_100_10 = '{'h0B, 'h31, 'h30, 'h30, 'h44, 'h30, 'h31, 'h30, 'h0A};
`else
    f_123_45 = '{'h0B, 'h31, 'h32, 'h33, 'h44, 'h34, 'h35, 'h0A};
    f_0_0    = '{'h0B, 'h30, 'h44, 'h30, 'h0A};
    f_5_600  = '{'h0B, 'h35, 'h44, 'h36, 'h30, 'h30, 'h0A};
    f_60_9   = '{'h0B, 'h36, 'h30, 'h44, 'h39, 'h0A};
    f_1_2    = '{'h0B, 'h31, 'h44, 'h32, 'h0A};
    f_7_42   = '{'h0B, 'h37, 'h44, 'h34, 'h32, 'h0A};
    f_100_10 = '{'h0B, 'h31, 'h30, 'h30, 'h44, 'h31, 'h30, 'h0A};
`endif
    f_sat = '{'h0B, 'h39, 'h39, 'h39, 'h44, 'h39, 'h39, 'h39, 'h0A};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_ready", coor_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_release", coor_ready, 1);
    chk("tx_idle_after_release", tx, 1);

    drive_pair(123, 45); coor_valid = 1'b0;
    check_frame("x123_y45", f_123_45);

    drive_pair(0, 0); coor_valid = 1'b0;
    check_frame("x0_y0", f_0_0);
    repeat (40) @(negedge clk);
    chk("x0_y0 single_done", done_q.size(), 0);
    chk("x0_y0 busy_low_after", busy, 0);
    chk("x0_y0 tx_idle_after", tx, 1);

    drive_pair(1023, 1000); coor_valid = 1'b0;
    check_frame("sat", f_sat);

    drive_pair(100, 10); coor_valid = 1'b0;
    check_frame("x100_y10", f_100_10);

    // coor_valid held high across two frames; inputs change mid-frame
    drive_pair(5, 600);
    coor_x = 10'd60; coor_y = 10'd9;
    check_frame("held_first", f_5_600);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!busy && n < 100);
    chk("held second_accept", busy, 1);
    coor_valid = 1'b0;
    check_frame("held_second", f_60_9);

    // Reset asserted during the x digits
    drive_pair(1, 2); coor_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!(rx_byte_q.size() >= 1 && tx === 1'b0) && n < 2000);
    chk("midrst reached_xdig", rx_byte_q.size() >= 1 && tx === 1'b0, 1);
    b = (rx_byte_q.size() > 0) ? rx_byte_q[0] : -1;
    chk("midrst sof_byte", b, 'h0B);
    rst_n = 1'b0;
    #1;
    chk("midrst tx_high_now", tx, 1);
    chk("midrst busy_low", busy, 0);
    chk("midrst ready_low", coor_ready, 0);
    repeat (3) @(negedge clk);
    chk("midrst tx_held_high", tx, 1);
    rst_n = 1'b1;
    rx_byte_q.delete(); rx_start_q.delete(); rx_clean_q.delete();
    acc_q.delete(); done_q.delete(); done_ok_q.delete();
    repeat (30) @(negedge clk);
    chk("postrst no_resume_tx", tx, 1);
    chk("postrst no_bytes", rx_byte_q.size(), 0);
    drive_pair(1, 2); coor_valid = 1'b0;
    check_frame("postrst_x1_y2", f_1_2);

    drive_pair(7, 42); coor_valid = 1'b0;
    check_frame("x7_y42", f_7_42);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
